alu_rr_scheduler: RTL and testbench

Shares one 8-bit ALU datapath between NUM_REQ requesters using round-robin arbitration.
- Each requester presents operands and an opcode with a valid/ready handshake.
- The winner's operands are registered and executed; the result returns on a single response channel tagged with the requester id, with backpressure.
- Sits between the ALU instance (`alu_eightbit`) and its clients; owns all sequencing of the shared ALU.

---
 rtl/alu_rr_scheduler.sv | 169 ++++++++++++++++
 tb/tb_alu_rr_scheduler.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one 8-bit ALU between NUM_REQ requesters.
// Sequence per operation: accept in IDLE, execute in EXEC, hold result in RESP.

module alu_eightbit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [2:0] op,
    output logic [7:0] result
);

    always_comb begin
        result = 8'h00;
        case (op)
            3'b000: result = a + b;
            3'b001: result = a - b;
            3'b010: result = (b >= 8'd8) ? 8'h00 : (a << b[2:0]);
            3'b011: result = (b >= 8'd8) ? 8'h00 : (a >> b[2:0]);
            3'b100: result = a & b;
            3'b101: result = a | b;
            3'b110: result = a ^ b;
            3'b111: result = (a == b) ? 8'h01 : 8'h00;
            default: result = 8'h00;
        endcase
    end

endmodule

module alu_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    input  logic [NUM_REQ*8-1:0]   req_a_i,
    input  logic [NUM_REQ*8-1:0]   req_b_i,
    input  logic [NUM_REQ*3-1:0]   req_op_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [7:0]             rsp_data_o,
    output logic [ID_W-1:0]        rsp_id_o,
    output logic                   busy_o,
    output logic [CNT_W-1:0]       op_count_o
);

    localparam int SLOTS = 1 << ID_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_reg;
    logic [7:0]        a_reg;
    logic [7:0]        b_reg;
    logic [2:0]        op_reg;
    logic [ID_W-1:0]   id_reg;
    logic [ID_W-1:0]   last_grant_reg;

    logic [7:0]        alu_result;
    logic [SLOTS-1:0]  valid_pad;
    logic [7:0]        a_arr  [SLOTS];
    logic [7:0]        b_arr  [SLOTS];
    logic [2:0]        op_arr [SLOTS];

    logic [ID_W-1:0]   grant;
    logic              grant_found;
    logic [ID_W:0]     cand;
    logic [SLOTS-1:0]  grant_onehot;

    // Pad the request set out to a power of two so any id-width index is in range.
    assign valid_pad = SLOTS'(req_valid_i);

    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_unpack
            if (gi < NUM_REQ) begin : g_live
                assign a_arr[gi]  = req_a_i[8*gi +: 8];
                assign b_arr[gi]  = req_b_i[8*gi +: 8];
                assign op_arr[gi] = req_op_i[3*gi +: 3];
            end else begin : g_pad
                assign a_arr[gi]  = 8'h00;
                assign b_arr[gi]  = 8'h00;
                assign op_arr[gi] = 3'b000;
            end
        end
    endgenerate

    // Search starts just after the last winner and wraps, so the last winner is checked last.
    always_comb begin
        grant       = last_grant_reg;
        grant_found = 1'b0;
        cand        = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = {1'b0, last_grant_reg} + (ID_W+1)'(off);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!grant_found && valid_pad[cand[ID_W-1:0]]) begin
                grant       = cand[ID_W-1:0];
                grant_found = 1'b1;
            end
        end
    end

    always_comb begin
        grant_onehot = '0;
        if (state_reg == IDLE && grant_found && reset_n) begin
            grant_onehot[grant] = 1'b1;
        end
    end

    assign req_ready_o = grant_onehot[NUM_REQ-1:0];
    assign busy_o      = (state_reg != IDLE);

    alu_eightbit u_alu (
        .a      (a_reg),
        .b      (b_reg),
        .op     (op_reg),
        .result (alu_result)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            a_reg          <= 8'h00;
            b_reg          <= 8'h00;
            op_reg         <= 3'b000;
            id_reg         <= '0;
            last_grant_reg <= ID_W'(NUM_REQ - 1);
            rsp_valid_o    <= 1'b0;
            rsp_data_o     <= 8'h00;
            rsp_id_o       <= '0;
            op_count_o     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_found) begin
                        a_reg          <= a_arr[grant];
                        b_reg          <= b_arr[grant];
                        op_reg         <= op_arr[grant];
                        id_reg         <= grant;
                        last_grant_reg <= grant;
                        state_reg      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data_o  <= alu_result;
                    rsp_id_o    <= id_reg;
                    rsp_valid_o <= 1'b1;
                    state_reg   <= RESP;
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        op_count_o  <= op_count_o + CNT_W'(1);
                        state_reg   <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Randomised and directed bench for alu_rr_scheduler with a queue-based scoreboard.
`timescale 1ns/1ps

module tb_alu_rr_scheduler;

    localparam int N     = 4;
    localparam int CNT_W = 4;

    logic              clk;
    logic              reset_n;
    logic [N-1:0]      req_valid_i;
    logic [N-1:0]      req_ready_o;
    logic [N*8-1:0]    req_a_i;
    logic [N*8-1:0]    req_b_i;
    logic [N*3-1:0]    req_op_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [7:0]        rsp_data_o;
    logic [1:0]        rsp_id_o;
    logic              busy_o;
    logic [CNT_W-1:0]  op_count_o;

    alu_rr_scheduler #(.NUM_REQ(N), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_a_i     (req_a_i),
        .req_b_i     (req_b_i),
        .req_op_i    (req_op_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o),
        .rsp_id_o    (rsp_id_o),
        .busy_o      (busy_o),
        .op_count_o  (op_count_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    // Requester-side model: pending flags and held payloads.
    bit       pend [N];
    bit [7:0] pa   [N];
    bit [7:0] pb   [N];
    bit [2:0] pop  [N];

    // Scheduler model: pointer to last winner, phase 0=idle 1=executing 2=holding result.
    int ptr;
    int phase;
    int exp_count;
    bit [7:0] exp_data [$];
    int       exp_id   [$];

    // Random traffic knobs.
    bit [N-1:0] fill_mask;
    int fill_pct, drop_pct, rdy_pct;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit [7:0] ref_alu(input bit [7:0] a, input bit [7:0] b, input bit [2:0] op);
        int ia = a;
        int ib = b;
        case (op)
            3'd0: return 8'((ia + ib) % 256);
            3'd1: return 8'((ia - ib + 256) % 256);
            3'd2: return (ib >= 8) ? 8'h00 : 8'((ia * (1 << ib)) % 256);
            3'd3: return (ib >= 8) ? 8'h00 : 8'(ia / (1 << ib));
            3'd4: return a & b;
            3'd5: return a | b;
            3'd6: return a ^ b;
            default: return (ia == ib) ? 8'h01 : 8'h00;
        endcase
    endfunction

    function automatic int pick();
        for (int off = 1; off <= N; off++) begin
            int k = (ptr + off) % N;
            if (pend[k]) return k;
        end
        return -1;
    endfunction

    task automatic post(input int k, input bit [7:0] a, input bit [7:0] b, input bit [2:0] op);
        pend[k] = 1'b1;
        pa[k]   = a;
        pb[k]   = b;
        pop[k]  = op;
    endtask

    task automatic post_random(input int k);
        bit [7:0] b;
        b = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 10)) : 8'($urandom);
        post(k, 8'($urandom), b, 3'($urandom_range(0, 7)));
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            req_valid_i[k]       = pend[k];
            req_a_i[8*k +: 8]    = pa[k];
            req_b_i[8*k +: 8]    = pb[k];
            req_op_i[3*k +: 3]   = pop[k];
        end
    endtask

    task automatic model_reset();
        ptr       = N - 1;
        phase     = 0;
        exp_count = 0;
        exp_data.delete();
        exp_id.delete();
    endtask

    // One clock cycle: drive, check at the falling edge, advance the model to the next rising edge.
    task automatic step(input bit rnd);
        int g;
        logic [N-1:0] exp_ready;
        if (rnd) begin
            for (int k = 0; k < N; k++) begin
                if (fill_mask[k] && !pend[k] && $urandom_range(0, 99) < fill_pct) post_random(k);
                else if (pend[k] && $urandom_range(0, 99) < drop_pct) pend[k] = 1'b0;
            end
            rsp_ready_i = ($urandom_range(0, 99) < rdy_pct);
        end
        drive();
        @(negedge clk);
        g = pick();
        exp_ready = '0;
        if (phase == 0 && g >= 0) exp_ready[g] = 1'b1;
        chk("req_ready", req_ready_o, exp_ready);
        chk("busy", busy_o, phase != 0);
        chk("rsp_valid", rsp_valid_o, phase == 2);
        chk("op_count", op_count_o, exp_count);
        if (phase == 0 && g >= 0) begin
            exp_data.push_back(ref_alu(pa[g], pb[g], pop[g]));
            exp_id.push_back(g);
            pend[g] = 1'b0;
            ptr     = g;
            phase   = 1;
        end else if (phase == 1) begin
            phase = 2;
        end else if (phase == 2 && rsp_ready_i) begin
            phase     = 0;
            exp_count = (exp_count + 1) % (1 << CNT_W);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_rsp_valid"}, rsp_valid_o, 0);
        chk({tag, "_rsp_data"}, rsp_data_o, 0);
        chk({tag, "_rsp_id"}, rsp_id_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_op_count"}, op_count_o, 0);
        chk({tag, "_req_ready"}, req_ready_o, 0);
    endtask

    task automatic mid_cycle_reset(input string tag);
        #2;
        reset_n = 1'b0;
        #1;
        check_zero_outputs(tag);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every presented response with the scoreboard head, pops on handshake.
    always @(negedge clk) begin
        if (reset_n && rsp_valid_o) begin
            if (exp_data.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                chk("rsp_data", rsp_data_o, exp_data[0]);
                chk("rsp_id", rsp_id_o, exp_id[0]);
                if (rsp_ready_i) begin
                    $display("rsp id=%0d data=%02h count_before=%0d", rsp_id_o, rsp_data_o, op_count_o);
                    void'(exp_data.pop_front());
                    void'(exp_id.pop_front());
                end
            end
        end
    end

    bit [7:0] t5_a  [5] = '{8'h00, 8'h81, 8'hF0, 8'h55, 8'h55};
    bit [7:0] t5_b  [5] = '{8'h01, 8'h01, 8'h09, 8'h55, 8'h54};
    bit [2:0] t5_op [5] = '{3'd1,  3'd2,  3'd3,  3'd7,  3'd7};

    initial begin
        for (int k = 0; k < N; k++) begin
            pend[k] = 1'b0; pa[k] = 8'h00; pb[k] = 8'h00; pop[k] = 3'd0;
        end
        fill_mask = '0; fill_pct = 0; drop_pct = 0; rdy_pct = 100;
        model_reset();
        reset_n     = 1'b0;
        rsp_ready_i = 1'b0;
        drive();

        // Reset state, including ready held low while all requesters are valid.
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset_idle");
        for (int k = 0; k < N; k++) post_random(k);
        drive();
        #1;
        check_zero_outputs("reset_valid");
        for (int k = 0; k < N; k++) pend[k] = 1'b0;
        drive();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Single ADD from requester 0.
        rsp_ready_i = 1'b1;
        post(0, 8'h0F, 8'h01, 3'd0);
        repeat (5) step(0);
        chk("single_count", op_count_o, 1);

        // All four valid after reset: grants rotate 0,1,2,3.
        mid_cycle_reset("reset_between");
        fill_mask = 4'b1111; fill_pct = 100; drop_pct = 0; rdy_pct = 100;
        repeat (14) step(1);
        fill_mask = '0;
        repeat (4) step(1);

        // Backpressure: hold the response for five cycles, then release it.
        rsp_ready_i = 1'b0;
        post(1, 8'h3C, 8'h0F, 3'd6);
        repeat (7) step(0);
        chk("bp_hold_valid", rsp_valid_o, 1);
        chk("bp_hold_busy", busy_o, 1);
        rsp_ready_i = 1'b1;
        repeat (3) step(0);

        // Fairness between requesters 0 and 2.
        fill_mask = 4'b0101; fill_pct = 100; drop_pct = 0; rdy_pct = 100;
        repeat (24) step(1);
        fill_mask = '0;
        repeat (4) step(1);

        // Arithmetic edge cases.
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            post(i % N, t5_a[i], t5_b[i], t5_op[i]);
            repeat (3) step(0);
        end
        repeat (2) step(0);

        // Reset while holding a response, then requesters 3 and 0 compete.
        rsp_ready_i = 1'b0;
        post(1, 8'hAA, 8'h11, 3'd0);
        repeat (4) step(0);
        chk("resp_before_reset", rsp_valid_o, 1);
        mid_cycle_reset("reset_resp");
        rsp_ready_i = 1'b1;
        post(3, 8'h10, 8'h20, 3'd5);
        post(0, 8'h07, 8'h03, 3'd4);
        repeat (8) step(0);

        // Long random run, which also wraps the narrow op counter.
        fill_mask = 4'b1111; fill_pct = 30; drop_pct = 5; rdy_pct = 70;
        repeat (800) step(1);

        // Drain.
        fill_mask = '0; rdy_pct = 100;
        for (int k = 0; k < N; k++) pend[k] = 1'b0;
        repeat (6) step(1);
        chk("drain_queue_empty", exp_data.size(), 0);
        chk("drain_idle", busy_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
